button_debouncer: RTL and testbench

//   Upstream conditioning stage for the stopwatch push-buttons (start/stop, clear/lap).

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/debounce_channel.sv | 135 +++++++++++++
 rtl/button_debouncer.sv | 47 ++++
 tb/tb_button_debouncer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
//   Definitions shared by the stopwatch front-end blocks.
//   - db_state_e        : 2-bit per-channel debounce state encoding
//   - DB_DEFAULT_CYCLES : stability window for 1 ms at a 50 MHz clock
//   - db_is_pending     : true while a candidate level change is being timed
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        DB_STABLE0 = 2'd0,  // released, no change being timed
        DB_PEND1   = 2'd1,  // released, timing a candidate press
        DB_STABLE1 = 2'd2,  // pressed, no change being timed
        DB_PEND0   = 2'd3   // pressed, timing a candidate release
    } db_state_e;

    localparam int DB_DEFAULT_CYCLES = 50000;

    function automatic logic db_is_pending(input db_state_e st);
        return (st == DB_PEND1) || (st == DB_PEND0);
    endfunction

endpackage : stopwatch_pkg

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One button channel: synchroniser, polarity correction, and a stability
//   FSM that accepts a new level only after it has been seen for
//   DEBOUNCE_CYCLES consecutive cycles. Any return to the old level while
//   timing aborts the candidate and the wait starts over on the next change.
//
// Ports
//   clk        in   system clock, rising edge
//   r_n        in   asynchronous active-low reset, synchronous release
//   btn_raw    in   raw button pin, asynchronous to clk
//   btn_level  out  registered debounced level, 1 = pressed
//   bouncing   out  1 while a candidate change is being timed
// -----------------------------------------------------------------------------
module debounce_channel
    import stopwatch_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = DB_DEFAULT_CYCLES,
    parameter int SYNC_STAGES     = 2,
    parameter bit ACTIVE_LOW_IN   = 1'b1
) (
    input  logic clk,
    input  logic r_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic bouncing
);

    // Terminal count: acceptance happens on the cycle the counter holds this.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Synchroniser resets to the pin's released level so that reset never
    // looks like a press, whatever the pin polarity.
    localparam logic [SYNC_STAGES-1:0] SYNC_RST = {SYNC_STAGES{ACTIVE_LOW_IN}};

    // ------------------------------------------------------------------
    // Synchroniser (raw pin domain, inverted only after the last stage)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;   // synchronised, 1 = pressed

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
    end

    // NOTE: every flop is updated with <= so all registers sample the values
    // from before the edge; blocking assignments here would collapse the chain.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            sync_q <= SYNC_RST;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW_IN;

    // ------------------------------------------------------------------
    // Stability FSM + counter
    // ------------------------------------------------------------------
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;

    always_comb begin
        // NOTE: hold values are assigned first so every path through the case
        // drives every output; a missing branch would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;

        unique case (state_q)
            DB_STABLE0: begin
                if (s) begin
                    state_d = DB_PEND1;
                    cnt_d   = '0;
                end
            end

            DB_PEND1: begin
                if (!s) begin
                    state_d = DB_STABLE0;      // bounce: discard candidate
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_STABLE1;
                    level_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            DB_STABLE1: begin
                if (!s) begin
                    state_d = DB_PEND0;
                    cnt_d   = '0;
                end
            end

            DB_PEND0: begin
                if (s) begin
                    state_d = DB_STABLE1;      // bounce: discard candidate
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_STABLE0;
                    level_d = 1'b0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = DB_STABLE0;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // NOTE: only control state is reset; there is no storage array here, and
    // the counter is cleared anyway on every entry into a pending state.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            state_q <= DB_STABLE0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign btn_level = level_q;
    assign bouncing  = db_is_pending(state_q);

endmodule : debounce_channel

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Conditioning stage for the stopwatch push-buttons. Each of the N raw
//   pins gets its own independent debounce_channel; channels share nothing,
//   so simultaneous presses are handled in parallel with no priority.
//
// Ports
//   clk        in      system clock, rising edge
//   r_n        in      asynchronous active-low reset
//   btn_raw    in  [N] raw button pins, asynchronous to clk
//   btn_level  out [N] debounced levels, 1 = pressed
//   bouncing   out [N] 1 while the channel is timing a candidate change
// -----------------------------------------------------------------------------
module button_debouncer
    import stopwatch_pkg::*;
#(
    parameter int N               = 2,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = DB_DEFAULT_CYCLES,
    parameter int SYNC_STAGES     = 2,
    parameter bit ACTIVE_LOW_IN   = 1'b1
) (
    input  logic         clk,
    input  logic         r_n,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] bouncing
);

    // Pin polarity is applied inside each channel after its synchroniser,
    // so the synchroniser can reset to the true released pin level.
    for (genvar i = 0; i < N; i++) begin : g_chan
        debounce_channel #(
            .CNT_W           (CNT_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .ACTIVE_LOW_IN   (ACTIVE_LOW_IN)
        ) u_chan (
            .clk       (clk),
            .r_n       (r_n),
            .btn_raw   (btn_raw[i]),
            .btn_level (btn_level[i]),
            .bouncing  (bouncing[i])
        );
    end

endmodule : button_debouncer

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//   Directed bench: DEBOUNCE_CYCLES=4, SYNC_STAGES=2, active-low pins, N=2.
//   Inputs are driven and outputs sampled 1 time unit after each rising
//   edge; "edge k" counts rising edges after the most recent input change.
//   A clean change yields bouncing from edge 3 and a new level on edge 7.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int N  = 2;
    localparam int DC = 4;

    logic         clk;
    logic         r_n;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] bouncing;

    int total = 0;
    int bad   = 0;

    button_debouncer #(
        .N               (N),
        .CNT_W           (16),
        .DEBOUNCE_CYCLES (DC),
        .SYNC_STAGES     (2),
        .ACTIVE_LOW_IN   (1'b1)
    ) dut (
        .clk       (clk),
        .r_n       (r_n),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .bouncing  (bouncing)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge; return 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let a channel settle well past the debounce window.
    task automatic settle();
        repeat (12) tick();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        r_n     = 1'b1;
        btn_raw = 2'b11;   // both released (active-low pins)

        // ---------------- 1: async reset mid-cycle ----------------
        #2;
        r_n = 1'b0;
        #1;
        check("rst_level_now", 32'(btn_level), 32'h0);
        check("rst_bounce_now", 32'(bouncing), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        r_n = 1'b1;
        repeat (4) tick();
        check("idle_level", 32'(btn_level), 32'h0);
        check("idle_bounce", 32'(bouncing), 32'h0);

        // ---------------- 2: clean press ch0 ----------------
        btn_raw[0] = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            check($sformatf("press_lvl_e%0d", e), 32'(btn_level), (e >= 7) ? 32'h1 : 32'h0);
            check($sformatf("press_bnc_e%0d", e), 32'(bouncing), (e >= 3 && e < 7) ? 32'h1 : 32'h0);
        end

        // ---------------- 3: bounce then hold pressed ----------------
        btn_raw[0] = 1'b1;
        settle();
        check("released_before_bounce", 32'(btn_level), 32'h0);
        for (int c = 0; c < 20; c++) begin
            btn_raw[0] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            check($sformatf("bounce_c%0d", c), 32'(btn_level), 32'h0);
        end
        btn_raw[0] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("after_bounce_e%0d", e), 32'(btn_level), (e >= 7) ? 32'h1 : 32'h0);
        end

        // ---------------- 4a: clean release ----------------
        btn_raw[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("release_e%0d", e), 32'(btn_level), (e >= 7) ? 32'h0 : 32'h1);
        end

        // ---------------- 4b: release with 3-cycle glitch ----------------
        btn_raw[0] = 1'b0;
        settle();
        check("repressed", 32'(btn_level), 32'h1);
        btn_raw[0] = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            tick();
            check($sformatf("glitch_lvl_e%0d", e), 32'(btn_level), (e >= 12) ? 32'h0 : 32'h1);
            check($sformatf("glitch_bnc_e%0d", e), 32'(bouncing),
                  (e == 3 || e == 4 || (e >= 8 && e < 12)) ? 32'h1 : 32'h0);
            if (e == 2) btn_raw[0] = 1'b0;
            if (e == 5) btn_raw[0] = 1'b1;
        end

        // ---------------- 5: simultaneous press ----------------
        btn_raw = 2'b00;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("simul_lvl_e%0d", e), 32'(btn_level), (e >= 7) ? 32'h3 : 32'h0);
            check($sformatf("simul_bnc_e%0d", e), 32'(bouncing), (e >= 3 && e < 7) ? 32'h3 : 32'h0);
        end
        btn_raw = 2'b11;
        settle();
        check("simul_released", 32'(btn_level), 32'h0);

        // ---------------- 6: reset in the middle of PEND1 ----------------
        btn_raw[0] = 1'b0;
        repeat (5) tick();   // edge 5: PEND1, count = 2
        check("pend_before_rst", 32'(bouncing), 32'h1);
        #3;
        r_n = 1'b0;
        #1;
        check("midpend_rst_level", 32'(btn_level), 32'h0);
        check("midpend_rst_bounce", 32'(bouncing), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        r_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("post_rst_lvl_e%0d", e), 32'(btn_level), (e >= 7) ? 32'h1 : 32'h0);
            check($sformatf("post_rst_bnc_e%0d", e), 32'(bouncing), (e >= 3 && e < 7) ? 32'h1 : 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_button_debouncer
